// File: rtl/spi_xfer_seq.sv
// Transfer sequencer in front of the SPI host core: buffers TX words, runs
// CFG/TX/GO/wait/read cycles on the core register bus, and queues RX words.
module spi_xfer_seq #(
    parameter int unsigned DEPTH     = 8,
    parameter logic [7:0]  ADDR_TX   = 8'h00,
    parameter logic [7:0]  ADDR_RX   = 8'h00,
    parameter logic [7:0]  ADDR_CTRL = 8'h10,
    parameter logic [31:0] CTRL_WORD = 32'h0000_F008,
    parameter int unsigned GO_BIT    = 8
) (
    input  logic                       clk_i,
    input  logic                       rst_ni,
    input  logic [31:0]                tx_data_i,
    input  logic                       tx_valid_i,
    output logic                       tx_ready_o,
    output logic [31:0]                rx_data_o,
    output logic                       rx_valid_o,
    input  logic                       rx_ready_i,
    output logic [7:0]                 core_addr_o,
    output logic [31:0]                core_wdata_o,
    output logic [3:0]                 core_be_o,
    output logic                       core_we_o,
    output logic                       core_re_o,
    input  logic [31:0]                core_rdata_i,
    input  logic                       core_done_i,
    output logic                       busy_o,
    output logic [$clog2(DEPTH):0]     tx_level_o,
    output logic [$clog2(DEPTH):0]     rx_level_o
);

    localparam int unsigned PW = $clog2(DEPTH);
    localparam int unsigned LW = PW + 1;
    localparam logic [LW-1:0] FULL_LVL = LW'(DEPTH);
    localparam logic [31:0]   GO_WORD  = CTRL_WORD | (32'd1 << GO_BIT);

    typedef enum logic [2:0] {
        S_IDLE, S_CFG, S_LOAD, S_GO, S_WAIT, S_READ, S_CAPT
    } state_t;

    state_t          state;
    logic            ctrl_init;

    logic [31:0]     tx_mem [DEPTH];
    logic [PW-1:0]   tx_wr, tx_rd;
    logic [LW-1:0]   tx_lvl;
    logic [31:0]     rx_mem [DEPTH];
    logic [PW-1:0]   rx_wr, rx_rd;
    logic [LW-1:0]   rx_lvl;

    logic            tx_push_c, tx_pop_c, rx_push_c, rx_pop_c, start_c;
    logic [31:0]     tx_head_c;

    assign tx_ready_o = (tx_lvl != FULL_LVL);
    assign rx_valid_o = (rx_lvl != '0);
    assign tx_level_o = tx_lvl;
    assign rx_level_o = rx_lvl;
    assign tx_head_c  = tx_mem[tx_rd];
    assign rx_data_o  = rx_valid_o ? rx_mem[rx_rd] : '0;

    // Start only with a TX word queued and a free RX slot for its reply.
    assign start_c   = (tx_lvl != '0) && (rx_lvl != FULL_LVL);
    assign tx_push_c = tx_valid_i && tx_ready_o;
    assign tx_pop_c  = ((state == S_IDLE) && start_c && ctrl_init) || (state == S_CFG);
    assign rx_push_c = (state == S_CAPT);
    assign rx_pop_c  = rx_ready_i && rx_valid_o;

    always_ff @(posedge clk_i) begin
        if (tx_push_c) tx_mem[tx_wr] <= tx_data_i;
        if (rx_push_c) rx_mem[rx_wr] <= core_rdata_i;
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            tx_wr  <= '0;
            tx_rd  <= '0;
            tx_lvl <= '0;
            rx_wr  <= '0;
            rx_rd  <= '0;
            rx_lvl <= '0;
        end else begin
            if (tx_push_c) tx_wr <= tx_wr + PW'(1);
            if (tx_pop_c)  tx_rd <= tx_rd + PW'(1);
            if (rx_push_c) rx_wr <= rx_wr + PW'(1);
            if (rx_pop_c)  rx_rd <= rx_rd + PW'(1);
            unique case ({tx_push_c, tx_pop_c})
                2'b10:   tx_lvl <= tx_lvl + LW'(1);
                2'b01:   tx_lvl <= tx_lvl - LW'(1);
                default: tx_lvl <= tx_lvl;
            endcase
            unique case ({rx_push_c, rx_pop_c})
                2'b10:   rx_lvl <= rx_lvl + LW'(1);
                2'b01:   rx_lvl <= rx_lvl - LW'(1);
                default: rx_lvl <= rx_lvl;
            endcase
        end
    end

    // Bus outputs are registered alongside the state they belong to.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state        <= S_IDLE;
            ctrl_init    <= 1'b0;
            core_addr_o  <= '0;
            core_wdata_o <= '0;
            core_be_o    <= 4'hF;
            core_we_o    <= 1'b0;
            core_re_o    <= 1'b0;
            busy_o       <= 1'b0;
        end else begin
            core_we_o <= 1'b0;
            core_re_o <= 1'b0;
            unique case (state)
                S_IDLE: begin
                    if (start_c) begin
                        busy_o    <= 1'b1;
                        core_we_o <= 1'b1;
                        if (ctrl_init) begin
                            state        <= S_LOAD;
                            core_addr_o  <= ADDR_TX;
                            core_wdata_o <= tx_head_c;
                        end else begin
                            state        <= S_CFG;
                            core_addr_o  <= ADDR_CTRL;
                            core_wdata_o <= CTRL_WORD;
                        end
                    end
                end
                S_CFG: begin
                    ctrl_init    <= 1'b1;
                    state        <= S_LOAD;
                    core_we_o    <= 1'b1;
                    core_addr_o  <= ADDR_TX;
                    core_wdata_o <= tx_head_c;
                end
                S_LOAD: begin
                    state        <= S_GO;
                    core_we_o    <= 1'b1;
                    core_addr_o  <= ADDR_CTRL;
                    core_wdata_o <= GO_WORD;
                end
                S_GO: state <= S_WAIT;
                S_WAIT: begin
                    if (core_done_i) begin
                        state       <= S_READ;
                        core_re_o   <= 1'b1;
                        core_addr_o <= ADDR_RX;
                    end
                end
                S_READ: state <= S_CAPT;
                S_CAPT: begin
                    state  <= S_IDLE;
                    busy_o <= 1'b0;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_spi_xfer_seq.sv
// Directed bench for spi_xfer_seq with a small reactive core model and
// scoreboards for the register-bus sequence and the returned RX words.
module tb_spi_xfer_seq;

    typedef struct packed {
        logic        we;
        logic        re;
        logic [7:0]  addr;
        logic [31:0] wdata;
    } bus_t;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [31:0] tx_data = '0;
    logic        tx_valid = 1'b0;
    logic        tx_ready;
    logic [31:0] rx_data;
    logic        rx_valid;
    logic        rx_ready = 1'b0;
    logic [7:0]  core_addr;
    logic [31:0] core_wdata;
    logic [3:0]  core_be;
    logic        core_we, core_re;
    logic [31:0] core_rdata = '0;
    logic        core_done;
    logic        busy;
    logic [3:0]  tx_level, rx_level;

    logic        done_auto = 1'b0;
    logic        done_man = 1'b0;
    logic        auto_en = 1'b1;
    int          done_dly = 20;
    int          cnt = 0;
    int          cyc = 0;
    logic [31:0] last_tx = '0;

    bus_t        obs_q[$];
    int          obs_cyc[$];
    bus_t        exp_bus[$];
    logic [31:0] exp_rx[$];
    int          rd_idx = 0;
    int          checks = 0;
    int          failures = 0;

    assign core_done = done_auto | done_man;

    always #5 clk = ~clk;

    spi_xfer_seq dut (
        .clk_i        (clk),
        .rst_ni       (rst_n),
        .tx_data_i    (tx_data),
        .tx_valid_i   (tx_valid),
        .tx_ready_o   (tx_ready),
        .rx_data_o    (rx_data),
        .rx_valid_o   (rx_valid),
        .rx_ready_i   (rx_ready),
        .core_addr_o  (core_addr),
        .core_wdata_o (core_wdata),
        .core_be_o    (core_be),
        .core_we_o    (core_we),
        .core_re_o    (core_re),
        .core_rdata_i (core_rdata),
        .core_done_i  (core_done),
        .busy_o       (busy),
        .tx_level_o   (tx_level),
        .rx_level_o   (rx_level)
    );

    // Core model: logs strobes, answers reads with last TX ^ 0xFF, pulses done after GO.
    always @(negedge clk) begin
        cyc = cyc + 1;
        done_auto = 1'b0;
        if (!rst_n) cnt = 0;
        else if (cnt > 0) begin
            cnt = cnt - 1;
            if (cnt == 0) done_auto = 1'b1;
        end
        if (core_we || core_re) begin
            obs_q.push_back({core_we, core_re, core_addr, core_we ? core_wdata : 32'h0});
            obs_cyc.push_back(cyc);
        end
        if (core_we && core_addr == 8'h00) last_tx = core_wdata;
        if (core_we && core_addr == 8'h10 && core_wdata[8] && auto_en) cnt = done_dly;
        if (core_re) core_rdata = last_tx ^ 32'hFF;
    end

    task automatic step(input int n = 1);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic bus_t wr(input logic [7:0] a, input logic [31:0] d);
        return {1'b1, 1'b0, a, d};
    endfunction

    function automatic bus_t rd(input logic [7:0] a);
        return {1'b0, 1'b1, a, 32'h0};
    endfunction

    task automatic exp_cfg();
        exp_bus.push_back(wr(8'h10, 32'h0000_F008));
    endtask

    task automatic exp_word(input logic [31:0] w);
        exp_bus.push_back(wr(8'h00, w));
        exp_bus.push_back(wr(8'h10, 32'h0000_F108));
        exp_bus.push_back(rd(8'h00));
        exp_rx.push_back(w ^ 32'hFF);
    endtask

    task automatic push_tx(input logic [31:0] w);
        int n = 0;
        while (!tx_ready && n < 200) begin step(); n++; end
        if (n >= 200) chk("tx_ready_timeout", 64'(tx_ready), 64'(1));
        tx_data  = w;
        tx_valid = 1'b1;
        step();
        tx_valid = 1'b0;
    endtask

    task automatic pop_rx();
        int n = 0;
        logic [31:0] e;
        while (!rx_valid && n < 300) begin step(); n++; end
        e = (exp_rx.size() > 0) ? exp_rx.pop_front() : 32'hDEAD_BEEF;
        chk("rx_data", 64'(rx_data), 64'(e));
        rx_ready = 1'b1;
        step();
        rx_ready = 1'b0;
    endtask

    task automatic wait_idle(input int lim);
        int n = 0;
        while ((busy || tx_level != 4'd0) && n < lim) begin step(); n++; end
        chk("idle_timeout", 64'(busy), 64'(0));
    endtask

    task automatic check_bus();
        int n;
        bus_t e;
        while (exp_bus.size() > 0) begin
            n = 0;
            while (obs_q.size() <= rd_idx && n < 300) begin step(); n++; end
            e = exp_bus.pop_front();
            if (obs_q.size() <= rd_idx) begin
                chk("bus_timeout", 64'(0), 64'(e));
                exp_bus.delete();
            end else begin
                chk("bus_txn", 64'(obs_q[rd_idx]), 64'(e));
                rd_idx++;
            end
        end
    endtask

    initial begin
        int base, nb, n;

        // Reset values
        step(2);
        chk("rst_addr", 64'(core_addr), 64'(0));
        chk("rst_wdata", 64'(core_wdata), 64'(0));
        chk("rst_be", 64'(core_be), 64'(4'hF));
        chk("rst_strobes", 64'({core_we, core_re}), 64'(0));
        chk("rst_flags", 64'({rx_valid, tx_ready, busy}), 64'(3'b010));
        chk("rst_levels", 64'({tx_level, rx_level}), 64'(0));
        chk("rst_rx_data", 64'(rx_data), 64'(0));
        rst_n = 1'b1;
        step();

        // Single word, done 20 clk after GO
        base = obs_q.size();
        exp_cfg();
        exp_word(32'hA5);
        push_tx(32'hA5);
        wait_idle(200);
        check_bus();
        chk("t1_rx_data", 64'(rx_data), 64'(32'h5A));
        chk("t1_flags", 64'({rx_valid, busy}), 64'(2'b10));
        if (obs_q.size() >= base + 4) begin
            chk("t1_cfg_to_go", 64'(obs_cyc[base+2] - obs_cyc[base]), 64'(2));
            chk("t1_go_to_read", 64'(obs_cyc[base+3] - obs_cyc[base+2]), 64'(21));
        end else begin
            chk("t1_obs_count", 64'(obs_q.size() - base), 64'(4));
        end
        pop_rx();
        chk("t1_rx_empty", 64'(rx_level), 64'(0));

        // Back-to-back: first word parked in WAIT while 8 more fill the TX FIFO
        done_dly = 3;
        auto_en  = 1'b0;
        exp_word(32'h100);
        push_tx(32'h100);
        step(6);
        auto_en = 1'b1;
        for (int i = 1; i <= 8; i++) begin
            exp_word(32'h100 + 32'(i));
            push_tx(32'h100 + 32'(i));
        end
        chk("t2_full_level", 64'(tx_level), 64'(8));
        chk("t2_full_ready", 64'(tx_ready), 64'(0));
        done_man = 1'b1;
        step();
        done_man = 1'b0;
        for (int i = 0; i < 9; i++) pop_rx();
        wait_idle(300);
        check_bus();
        chk("t2_ready_back", 64'(tx_ready), 64'(1));

        // RX full backpressure
        for (int i = 0; i < 8; i++) begin
            exp_word(32'h200 + 32'(i));
            push_tx(32'h200 + 32'(i));
        end
        n = 0;
        while ((rx_level != 4'd8 || busy || tx_level != 4'd0) && n < 400) begin step(); n++; end
        chk("t3_rx_full", 64'(rx_level), 64'(8));
        nb = obs_q.size();
        exp_word(32'h300);
        push_tx(32'h300);
        step(5);
        chk("t3_stalled_busy", 64'(busy), 64'(0));
        chk("t3_stalled_bus", 64'(obs_q.size()), 64'(nb));
        chk("t3_stalled_txlvl", 64'(tx_level), 64'(1));
        pop_rx();
        n = 0;
        while (obs_q.size() == nb && n < 2) begin step(); n++; end
        chk("t3_restart", 64'(obs_q.size() > nb), 64'(1));
        for (int i = 0; i < 8; i++) pop_rx();
        wait_idle(300);
        check_bus();

        // Stray done pulses in IDLE and LOAD
        auto_en = 1'b0;
        nb = obs_q.size();
        done_man = 1'b1;
        step();
        done_man = 1'b0;
        step(3);
        chk("t4_idle_busy", 64'(busy), 64'(0));
        chk("t4_idle_bus", 64'(obs_q.size()), 64'(nb));
        exp_word(32'h400);
        push_tx(32'h400);
        step();
        chk("t4_in_load", 64'({core_we, core_addr}), 64'({1'b1, 8'h00}));
        done_man = 1'b1;
        step();
        done_man = 1'b0;
        step(10);
        chk("t4_still_wait", 64'({busy, core_re}), 64'(2'b10));
        chk("t4_wait_bus", 64'(obs_q.size()), 64'(nb + 2));
        done_man = 1'b1;
        step();
        done_man = 1'b0;
        wait_idle(100);
        check_bus();
        pop_rx();

        // Reset during WAIT, then CFG must be re-issued
        exp_bus.push_back(wr(8'h00, 32'h500));
        exp_bus.push_back(wr(8'h10, 32'h0000_F108));
        push_tx(32'h500);
        step(8);
        check_bus();
        rst_n = 1'b0;
        #1;
        chk("t5_async_busy", 64'(busy), 64'(0));
        chk("t5_async_levels", 64'({tx_level, rx_level}), 64'(0));
        chk("t5_async_bus", 64'({core_we, core_re, core_addr, core_wdata, core_be}), 64'(4'hF));
        chk("t5_async_flags", 64'({tx_ready, rx_valid}), 64'(2'b10));
        step();
        rst_n = 1'b1;
        step();
        done_man = 1'b1;
        step();
        done_man = 1'b0;
        step(3);
        chk("t5_post_busy", 64'(busy), 64'(0));
        auto_en  = 1'b1;
        done_dly = 4;
        exp_cfg();
        exp_word(32'h600);
        push_tx(32'h600);
        wait_idle(100);
        check_bus();
        pop_rx();

        // RX pop coinciding with CAPT push at level 3
        done_dly = 3;
        for (int i = 0; i < 3; i++) begin
            exp_word(32'h700 + 32'(i));
            push_tx(32'h700 + 32'(i));
        end
        n = 0;
        while ((rx_level != 4'd3 || busy || tx_level != 4'd0) && n < 300) begin step(); n++; end
        chk("t6_level3", 64'(rx_level), 64'(3));
        exp_word(32'h703);
        push_tx(32'h703);
        n = 0;
        while (!core_re && n < 100) begin step(); n++; end
        chk("t6_read_seen", 64'(core_re), 64'(1));
        step();
        chk("t6_capt_level", 64'(rx_level), 64'(3));
        chk("t6_capt_head", 64'(rx_data), 64'(32'h700 ^ 32'hFF));
        rx_ready = 1'b1;
        step();
        rx_ready = 1'b0;
        void'(exp_rx.pop_front());
        chk("t6_level_kept", 64'(rx_level), 64'(3));
        chk("t6_head_adv", 64'(rx_data), 64'(32'h701 ^ 32'hFF));
        for (int i = 0; i < 3; i++) pop_rx();
        wait_idle(100);
        check_bus();

        step(3);
        chk("no_extra_strobes", 64'(obs_q.size()), 64'(rd_idx));
        chk("rx_drained", 64'(rx_level), 64'(0));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
